// File: rtl/bsg_logic_op_pkg.sv
// Shared types for the parametrised logic-op pipeline.
package bsg_logic_op_pkg;

    localparam int unsigned op_width_lp = 3;

    typedef enum logic [op_width_lp-1:0] {
        e_nor  = 3'd0,
        e_or   = 3'd1,
        e_nand = 3'd2,
        e_and  = 3'd3,
        e_xor  = 3'd4,
        e_xnor = 3'd5,
        e_pass = 3'd6,
        e_rsvd = 3'd7
    } bsg_logic_op_e;

endpackage

// File: rtl/bsg_logic_op_stage.sv
// One elastic 1-entry register slice: loads when empty or when draining this cycle.
module bsg_logic_op_stage
    import bsg_logic_op_pkg::*;
#(
    parameter int unsigned width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    assign ready_o = ~v_o | yumi_i;

    // Valid bit and payload; a new entry wins over a simultaneous drain.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_o    <= 1'b0;
            data_o <= '0;
        end else if (v_i && ready_o) begin
            v_o    <= 1'b1;
            data_o <= data_i;
        end else if (yumi_i) begin
            v_o    <= 1'b0;
        end
    end

endmodule

// File: rtl/bsg_logic_op_pipe.sv
// Bitwise reduction of els_p operand words followed by a stages_p-deep elastic pipe.
module bsg_logic_op_pipe
    import bsg_logic_op_pkg::*;
#(
    parameter int unsigned width_p  = 16,
    parameter int unsigned els_p    = 2,
    parameter int unsigned stages_p = 1
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic                            v_i,
    output logic                            ready_o,
    input  logic [els_p*width_p-1:0]        data_i,
    input  logic [op_width_lp-1:0]          op_i,
    output logic                            v_o,
    output logic [width_p-1:0]              data_o,
    input  logic                            yumi_i,
    output logic [$clog2(stages_p+1)-1:0]   count_o
);

    localparam int unsigned cnt_w_lp = $clog2(stages_p + 1);

    if (stages_p == 0 || els_p == 0) begin : g_bad_param
        $fatal(1, "bsg_logic_op_pipe: stages_p and els_p must both be >= 1");
    end

    // Combinational reduction of all operands; reserved op behaves as NOR.
    function automatic logic [width_p-1:0] reduce_op(
        input logic [els_p*width_p-1:0] d,
        input logic [op_width_lp-1:0]   op
    );
        logic [width_p-1:0] r_or;
        logic [width_p-1:0] r_and;
        logic [width_p-1:0] r_xor;
        logic [width_p-1:0] res;
        r_or  = '0;
        r_and = '1;
        r_xor = '0;
        res   = '0;
        for (int k = 0; k < int'(els_p); k++) begin
            r_or  = r_or  | d[k*width_p +: width_p];
            r_and = r_and & d[k*width_p +: width_p];
            r_xor = r_xor ^ d[k*width_p +: width_p];
        end
        case (bsg_logic_op_e'(op))
            e_nor:   res = ~r_or;
            e_or:    res = r_or;
            e_nand:  res = ~r_and;
            e_and:   res = r_and;
            e_xor:   res = r_xor;
            e_xnor:  res = ~r_xor;
            e_pass:  res = d[width_p-1:0];
            e_rsvd:  res = ~r_or;
            default: res = ~r_or;
        endcase
        return res;
    endfunction

    logic [width_p-1:0] result;
    logic               accept;

    assign result = reduce_op(data_i, op_i);

    // Stage chain: each stage drains when its successor accepts; the last drains on yumi_i.
    for (genvar s = 0; s < int'(stages_p); s++) begin : g_stage
        logic               v_in;
        logic [width_p-1:0] d_in;
        logic               rdy;
        logic               vld;
        logic [width_p-1:0] dat;
        logic               take;

        if (s == 0) begin : g_head
            assign v_in = v_i;
            assign d_in = result;
        end else begin : g_link
            assign v_in = g_stage[s-1].vld;
            assign d_in = g_stage[s-1].dat;
        end

        if (s == int'(stages_p) - 1) begin : g_tail
            assign take = yumi_i;
        end else begin : g_mid
            assign take = vld & g_stage[s+1].rdy;
        end

        bsg_logic_op_stage #(
            .width_p (width_p)
        ) u_stage (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .v_i       (v_in),
            .ready_o   (rdy),
            .data_i    (d_in),
            .v_o       (vld),
            .data_o    (dat),
            .yumi_i    (take)
        );
    end

    // Held low during reset so no producer handshakes against a clearing pipe.
    assign ready_o = g_stage[0].rdy & reset_n_i;
    assign v_o     = g_stage[stages_p-1].vld;
    assign data_o  = g_stage[stages_p-1].dat;
    assign accept  = v_i & ready_o;

    // Occupancy: up on accept, down on yumi, unchanged on both or neither.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_o <= '0;
        end else if (accept && !yumi_i) begin
            count_o <= count_o + cnt_w_lp'(1);
        end else if (!accept && yumi_i) begin
            count_o <= count_o - cnt_w_lp'(1);
        end
    end

    // A consumer must never take from an empty output.
    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(yumi_i && !v_o))
        else $error("bsg_logic_op_pipe: yumi_i asserted while v_o is low");

endmodule

// File: tb/tb_bsg_logic_op_pipe.sv
// Randomised scoreboard bench for bsg_logic_op_pipe (width 16, three operands, three stages).
module tb_bsg_logic_op_pipe;

    localparam int unsigned W = 16;
    localparam int unsigned E = 3;
    localparam int unsigned S = 3;
    localparam int unsigned CW = $clog2(S + 1);

    logic            clk_i;
    logic            reset_n_i;
    logic            v_i;
    logic            ready_o;
    logic [E*W-1:0]  data_i;
    logic [2:0]      op_i;
    logic            v_o;
    logic [W-1:0]    data_o;
    logic            yumi_i;
    logic [CW-1:0]   count_o;

    bsg_logic_op_pipe #(
        .width_p  (W),
        .els_p    (E),
        .stages_p (S)
    ) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (v_i),
        .ready_o   (ready_o),
        .data_i    (data_i),
        .op_i      (op_i),
        .v_o       (v_o),
        .data_o    (data_o),
        .yumi_i    (yumi_i),
        .count_o   (count_o)
    );

    typedef struct {
        logic [W-1:0] data;
        int           cyc;
        bit           lat;
    } exp_t;

    exp_t         sb[$];
    int           n_chk = 0;
    int           n_pass = 0;
    int           cyc = 0;
    int           mode = 1;      // 0 random yumi, 1 hold, 2 always take
    int           exp_cnt = 0;
    bit           stall_prev = 0;
    logic [W-1:0] prev_data = '0;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    always @(posedge clk_i) cyc++;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endfunction

    // Per-bit population count decides every op; reserved 7 behaves as NOR.
    function automatic logic [W-1:0] model(input logic [E*W-1:0] d, input logic [2:0] op);
        logic [W-1:0] r;
        logic [W-1:0] w [E];
        r = '0;
        for (int k = 0; k < int'(E); k++) w[k] = d[k*W +: W];
        for (int i = 0; i < int'(W); i++) begin
            int ones;
            ones = 0;
            for (int k = 0; k < int'(E); k++) ones += int'(w[k][i]);
            case (op)
                3'd1:    r[i] = (ones > 0);
                3'd2:    r[i] = (ones < int'(E));
                3'd3:    r[i] = (ones == int'(E));
                3'd4:    r[i] = (ones % 2 == 1);
                3'd5:    r[i] = (ones % 2 == 0);
                3'd6:    r[i] = w[0][i];
                default: r[i] = (ones == 0);
            endcase
        end
        return r;
    endfunction

    // Consumer: takes only when the DUT shows a valid result.
    always @(posedge clk_i) begin
        #1;
        case (mode)
            2:       yumi_i = v_o;
            1:       yumi_i = 1'b0;
            default: yumi_i = v_o & ($urandom_range(0, 1) == 1);
        endcase
    end

    // Monitor: checks occupancy, ready, output stability and pops the scoreboard.
    always @(negedge clk_i) begin
        if (reset_n_i) begin
            chk("count", 32'(count_o), 32'(exp_cnt));
            chk("ready", 32'(ready_o), 32'((exp_cnt < int'(S)) || yumi_i));
            if (stall_prev) begin
                chk("hold_valid", 32'(v_o), 32'd1);
                chk("hold_data", 32'(data_o), 32'(prev_data));
            end
            if (v_o && yumi_i) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL underflow: got data %0h expected no output at %0t", data_o, $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("data", 32'(data_o), 32'(e.data));
                    if (e.lat) chk("latency", 32'(cyc - e.cyc), 32'(S));
                end
            end
            stall_prev = v_o && !yumi_i;
            prev_data  = data_o;
            exp_cnt    = exp_cnt + int'(v_i && ready_o) - int'(v_o && yumi_i);
        end
    end

    // Present one transaction and hold it until accepted; expected value queued at the handshake.
    task automatic send(input logic [E*W-1:0] d, input logic [2:0] op, input logic [W-1:0] exp, input bit lat);
        bit done;
        done   = 0;
        v_i    = 1'b1;
        data_i = d;
        op_i   = op;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk_i);
            if (ready_o) begin
                sb.push_back('{exp, cyc, lat});
                done = 1;
            end
            @(posedge clk_i);
            #1;
        end
        if (!done) begin
            n_chk++;
            $display("FAIL accept_timeout: got ready_o=0 for 200 cycles expected 1 at %0t", $time);
        end
    endtask

    task automatic idle(input int n);
        v_i    = 1'b0;
        data_i = {$urandom, $urandom};
        op_i   = 3'($urandom_range(0, 7));
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic drain();
        mode = 2;
        v_i  = 1'b0;
        for (int t = 0; t < 60 && (sb.size() != 0 || count_o != 0); t++) begin
            @(posedge clk_i);
            #1;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic send_rand(input bit lat);
        logic [E*W-1:0] d;
        logic [2:0]     op;
        d  = {$urandom, $urandom};
        op = 3'($urandom_range(0, 7));
        send(d, op, model(d, op), lat);
    endtask

    initial begin
        logic [E*W-1:0] dir;
        reset_n_i = 1'b0;
        v_i       = 1'b0;
        data_i    = '0;
        op_i      = '0;
        yumi_i    = 1'b0;

        // Reset with random inputs toggling.
        repeat (4) begin
            @(posedge clk_i);
            #1;
            v_i    = $urandom_range(0, 1) == 1;
            data_i = {$urandom, $urandom};
            op_i   = 3'($urandom_range(0, 7));
            @(negedge clk_i);
            chk("rst_v_o", 32'(v_o), 32'd0);
            chk("rst_data_o", 32'(data_o), 32'd0);
            chk("rst_count_o", 32'(count_o), 32'd0);
            chk("rst_ready_o", 32'(ready_o), 32'd0);
        end
        v_i = 1'b0;
        #2 reset_n_i = 1'b1;
        #1 chk("release_ready", 32'(ready_o), 32'd1);
        @(posedge clk_i);
        #1;

        // Directed ops on a=00F0, b=0F00, c=0000.
        mode = 2;
        dir  = {16'h0000, 16'h0F00, 16'h00F0};
        send(dir, 3'd0, 16'hF00F, 1'b1);
        idle(4);
        send(dir, 3'd4, 16'h0FF0, 1'b1);
        idle(4);
        for (int op = 1; op < 8; op++) begin
            send(dir, 3'(op), model(dir, 3'(op)), 1'b1);
            idle(4);
        end

        // Back-to-back stream with the consumer always taking.
        for (int i = 0; i < 100; i++) send_rand(1'b1);
        idle(1);
        drain();

        // Back-pressure: fill, check stall, then release with a pending input on a full pipe.
        mode = 1;
        for (int i = 0; i < int'(S); i++) send_rand(1'b0);
        fork
            send_rand(1'b0);
            begin
                repeat (4) @(negedge clk_i);
                #1;
                chk("bp_ready", 32'(ready_o), 32'd0);
                chk("bp_count", 32'(count_o), 32'(S));
                #1 mode = 2;
            end
        join
        for (int i = 0; i < 10; i++) send_rand(1'b0);
        idle(1);
        drain();

        // Random gaps and random consumer stalls.
        mode = 0;
        for (int i = 0; i < 80; i++) begin
            send_rand(1'b0);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(1);
        drain();

        // Reset in the middle with two entries in flight.
        mode = 1;
        send_rand(1'b0);
        send_rand(1'b0);
        idle(4);
        @(negedge clk_i);
        chk("pre_rst_v_o", 32'(v_o), 32'd1);
        chk("pre_rst_count", 32'(count_o), 32'd2);
        #2 reset_n_i = 1'b0;
        #1;
        chk("mid_rst_v_o", 32'(v_o), 32'd0);
        chk("mid_rst_count", 32'(count_o), 32'd0);
        chk("mid_rst_ready", 32'(ready_o), 32'd0);
        chk("mid_rst_data", 32'(data_o), 32'd0);
        sb.delete();
        exp_cnt    = 0;
        stall_prev = 0;
        mode       = 2;
        repeat (2) @(negedge clk_i);
        #2 reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        send_rand(1'b1);
        idle(1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
